// File: rtl/stat_disp_pkg.sv
// Shared definitions for the statistics display reader: glyphs, converter FSM states, select codes.
// Glyphs are for a common-anode display, active-low, bit order {dp,g,f,e,d,c,b,a}.
package stat_disp_pkg;

    localparam int DISP_DIGITS = 8;
    localparam int BCD_DIGITS  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    localparam logic [1:0] SEL_CYCLES   = 2'd0;
    localparam logic [1:0] SEL_JUMPS    = 2'd1;
    localparam logic [1:0] SEL_BRANCHES = 2'd2;
    localparam logic [1:0] SEL_BUBBLES  = 2'd3;

    localparam logic [7:0] GLYPH_0     = 8'hC0;
    localparam logic [7:0] GLYPH_1     = 8'hF9;
    localparam logic [7:0] GLYPH_2     = 8'hA4;
    localparam logic [7:0] GLYPH_3     = 8'hB0;
    localparam logic [7:0] GLYPH_4     = 8'h99;
    localparam logic [7:0] GLYPH_5     = 8'h92;
    localparam logic [7:0] GLYPH_6     = 8'h82;
    localparam logic [7:0] GLYPH_7     = 8'hF8;
    localparam logic [7:0] GLYPH_8     = 8'h80;
    localparam logic [7:0] GLYPH_9     = 8'h90;
    localparam logic [7:0] GLYPH_A     = 8'h88;
    localparam logic [7:0] GLYPH_B     = 8'h83;
    localparam logic [7:0] GLYPH_C     = 8'hC6;
    localparam logic [7:0] GLYPH_D     = 8'hA1;
    localparam logic [7:0] GLYPH_E     = 8'h86;
    localparam logic [7:0] GLYPH_F     = 8'h8E;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;

    // Decimal nibbles never exceed 9, so the A-F entries are only reachable in hex mode.
    function automatic logic [7:0] nibble_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/stat_display_reader_bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter: one LOAD cycle, CNT_W SHIFT cycles, one DONE cycle.
// din is sampled only in LOAD; bcd is valid while done is high.
module bin2bcd_serial
    import stat_disp_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        din,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CW    = $clog2(CNT_W + 1);

    conv_state_t        state_reg, state_next;
    logic [CNT_W-1:0]   bin_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CW-1:0]      bit_cnt_reg;

    // Add 3 to every digit of 5 or more so the following shift carries correctly into the next digit.
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                                : bcd_reg[gi*4 +: 4];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (bit_cnt_reg == CW'(CNT_W - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_reg     <= '0;
            bcd_reg     <= '0;
            bit_cnt_reg <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    bin_reg     <= din;
                    bcd_reg     <= '0;
                    bit_cnt_reg <= '0;
                end
                SHIFT: begin
                    {bcd_reg, bin_reg} <= {bcd_adj[BCD_W-2:0], bin_reg, 1'b0};
                    bit_cnt_reg        <= bit_cnt_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign bcd  = bcd_reg;

endmodule

// File: rtl/stat_display_reader.sv
// Shows one of four statistics counters on an 8-digit multiplexed 7-segment display.
// Define STAT_DISP_HEX_EN to show the raw value in hex (no BCD engine) instead of decimal.
module stat_display_reader
    import stat_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int UPDATE_DIV  = 5000000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt0,
    input  logic [CNT_W-1:0] cnt1,
    input  logic [CNT_W-1:0] cnt2,
    input  logic [CNT_W-1:0] cnt3,
    input  logic [1:0]       sel,
    input  logic             hold,
    output logic [7:0]       seg,
    output logic [7:0]       an,
    output logic             busy
);

    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int UW = $clog2(UPDATE_DIV + 1);

    logic [UW-1:0]                   upd_cnt_reg;
    logic [RW-1:0]                   ref_cnt_reg;
    logic [2:0]                      idx_reg;
    logic [1:0]                      sel_reg;
    logic                            pending_reg, pending_next;
    logic [DISP_DIGITS-1:0][7:0]     disp_reg, disp_next;
    logic [7:0]                      an_reg, seg_reg;

    logic                            tick, req, start, ref_wrap;
    logic                            conv_idle, conv_done, overflow;
    logic [CNT_W-1:0]                cnt_mux;
    logic [4*DISP_DIGITS-1:0]        nib_src;

    always_comb begin
        cnt_mux = cnt0;
        case (sel)
            SEL_CYCLES:   cnt_mux = cnt0;
            SEL_JUMPS:    cnt_mux = cnt1;
            SEL_BRANCHES: cnt_mux = cnt2;
            SEL_BUBBLES:  cnt_mux = cnt3;
            default:      cnt_mux = cnt0;
        endcase
    end

    assign tick  = (upd_cnt_reg == UW'(UPDATE_DIV - 1));
    assign req   = tick || (sel != sel_reg);
    assign start = conv_idle && !hold && (req || pending_reg);

    // One-deep request memory; hold throws it away rather than deferring it.
    always_comb begin
        pending_next = pending_reg;
        if (hold || start) begin
            pending_next = 1'b0;
        end else if (req && !conv_idle) begin
            pending_next = 1'b1;
        end
    end

`ifdef STAT_DISP_HEX_EN
    logic load_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_reg <= 1'b0;
        end else begin
            load_reg <= start;
        end
    end

    assign conv_idle = !load_reg;
    assign conv_done = load_reg;
    assign busy      = load_reg;
    assign overflow  = 1'b0;
    assign nib_src   = (4*DISP_DIGITS)'(cnt_mux);
`else
    logic [4*BCD_DIGITS-1:0] bcd;
    logic                    eng_busy;

    bin2bcd_serial #(
        .CNT_W (CNT_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (cnt_mux),
        .busy  (eng_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    assign conv_idle = !eng_busy;
    assign busy      = eng_busy;
    assign overflow  = |bcd[4*BCD_DIGITS-1:4*DISP_DIGITS];
    assign nib_src   = bcd[4*DISP_DIGITS-1:0];
`endif

    // A digit is lit when it or any higher digit is non-zero; digit 0 always shows.
    for (genvar gi = 0; gi < DISP_DIGITS; gi++) begin : g_digit
        logic shown;
        if (gi == 0) begin : g_lsd
            assign shown = 1'b1;
        end else begin : g_upper
            assign shown = |nib_src[4*DISP_DIGITS-1:gi*4];
        end
        assign disp_next[gi] = overflow ? GLYPH_DASH
                             : shown    ? nibble_glyph(nib_src[gi*4 +: 4])
                             :            GLYPH_BLANK;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_cnt_reg <= '0;
            sel_reg     <= '0;
            pending_reg <= 1'b0;
            disp_reg    <= {DISP_DIGITS{GLYPH_BLANK}};
        end else begin
            upd_cnt_reg <= tick ? '0 : upd_cnt_reg + 1'b1;
            sel_reg     <= sel;
            pending_reg <= pending_next;
            if (conv_done) begin
                disp_reg <= disp_next;
            end
        end
    end

    assign ref_wrap = (ref_cnt_reg == RW'(REFRESH_DIV - 1));

    // Anode and glyph come from the same index in the same clock, so they always change together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt_reg <= '0;
            idx_reg     <= '0;
            an_reg      <= 8'hFF;
            seg_reg     <= 8'hFF;
        end else begin
            ref_cnt_reg <= ref_wrap ? '0 : ref_cnt_reg + 1'b1;
            if (ref_wrap) begin
                idx_reg <= idx_reg + 1'b1;
            end
            an_reg  <= ~(8'b1 << idx_reg);
            seg_reg <= disp_reg[idx_reg] | 8'h80;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;

endmodule
